opcode_encoder: RTL and testbench
=================================

Name: opcode_encoder

Overview:
Encoder/issuer for the 4-bit casez-style opcode bus. It takes three 2-bit operand sources (a, b, c), each with a valid/ready handshake, and arbitrates among them with fixed priority and anti-starvation. It emits a registered opcode, data and valid toward the downstream opcode decoder. Encoding: a = 4'b1ttt, b = 4'b01tt, c = 4'b001t, idle = 4'b0000, where t is a rolling sequence tag.

Parameters:
STARVE_LIMIT, 8, cycles b or c may wait with valid high and no grant before being promoted above a (1..255)
CNT_W, 8, width of the starvation counters (must hold STARVE_LIMIT)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
a_valid  input  1  source a has data
a_data  input  2  source a operand
a_ready  output  1  source a accepted this cycle
b_valid  input  1  source b has data
b_data  input  2  source b operand
b_ready  output  1  source b accepted this cycle
c_valid  input  1  source c has data
c_data  input  2  source c operand
c_ready  output  1  source c accepted this cycle
opcode  output  4  encoded opcode (registered)
out_data  output  2  selected operand (registered)
out_valid  output  1  opcode/out_data valid
out_ready  input  1  downstream accepts

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: opcode=4'b0000, out_data=2'b00, out_valid=0, tag=3'b000, both starvation counters=0. a_ready, b_ready and c_ready are 0 while reset is high.
- load = !out_valid || out_ready. This is the output-slot-free condition and is combinational.
- Grant priority (combinational) when load=1:
  - starved b (b_cnt==STARVE_LIMIT and b_valid) wins first.
  - Otherwise starved c wins.
  - Otherwise a_valid, then b_valid, then c_valid.
- x_ready = load && grant==x. At most one ready is high. A source transfers when x_valid && x_ready.
- On a transfer, the registers update at the next edge:
  - out_data = x_data; out_valid = 1.
  - opcode: a -> {1'b1, tag[2:0]}; b -> {2'b01, tag[1:0]}; c -> {3'b001, tag[0]}.
  - tag increments by 1, mod 8.
- load=1 with no source valid: out_valid=0, opcode=4'b0000, out_data held, tag held.
- load=0 (out_valid=1, out_ready=0): opcode, out_data and out_valid hold stable. No ready is asserted.
- Latency: transfer at cycle N -> out_valid at N+1. Back-to-back transfers give 1 opcode/cycle when out_ready is held high.
- Starvation counters, b_cnt and c_cnt, evaluated at each edge:
  - Clear to 0 when the source is granted or its valid is low.
  - Otherwise increment, saturating at STARVE_LIMIT. Stalls (load=0) also count.
- Simultaneous events:
  - Grant and a counter reaching the limit in the same cycle: the grant wins and the counter clears.
  - Both b and c starved: b granted; c stays saturated and wins next.
- Source valid drop without ready: permitted. Nothing is captured and the counter clears.
- Reset mid-transaction: the held output is discarded, out_valid=0 next cycle, tag restarts at 0.
- The encoder never emits 4'b0000 with out_valid=1. Every emitted opcode matches exactly one decoder pattern (1zzx, 01??, 001?).

Test Plan:
- Reset, then a_valid=1, a_data=2'b00, out_ready=1 -> a_ready=1 same cycle; next cycle opcode=4'b1000, out_data=00, out_valid=1; a second a transfer gives opcode=4'b1001.
- a, b, c all valid, out_ready=1 for 3 cycles, STARVE_LIMIT=8 -> a granted each cycle with opcodes 1000, 1001, 1010; b_cnt=3, c_cnt=3.
- a always valid, b valid, STARVE_LIMIT=4 -> b granted on the 5th cycle, opcode={2'b01, tag[1:0]}, b_cnt clears, a resumes next cycle.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with c_valid=1 -> opcode/out_data stable, c_ready=0 throughout; out_ready=1 -> c granted, opcode=001t next cycle.
- Only c_valid, 10 transfers -> opcode bit0 toggles with tag (0010, 0011, ...), tag wraps 7->0.
- reset asserted while out_valid=1 -> next cycle out_valid=0, opcode=0000, a new a transfer gives opcode=1000.

Source files
------------

// File: rtl/opcode_encoder.sv
// Three-source opcode issuer: fixed priority a > b > c with starvation
// promotion of b and c, registered opcode/data/valid toward the decoder.
module opcode_encoder #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic [1:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [1:0] b_data,
    output logic       b_ready,
    input  logic       c_valid,
    input  logic [1:0] c_data,
    output logic       c_ready,
    output logic [3:0] opcode,
    output logic [1:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [3:0]       opcode_q, opcode_d;
    logic [1:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic [2:0]       tag_q, tag_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
    logic [CNT_W-1:0] c_cnt_q, c_cnt_d;

    logic load;
    logic b_starved, c_starved;
    logic gnt_a, gnt_b, gnt_c;

    assign load      = !valid_q || out_ready;
    assign b_starved = b_valid && (b_cnt_q == LIMIT);
    assign c_starved = c_valid && (c_cnt_q == LIMIT);

    // Starved b/c jump ahead of a; otherwise plain a > b > c.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        gnt_c = 1'b0;
        if (load && !reset) begin
            if (b_starved)    gnt_b = 1'b1;
            else if (c_starved) gnt_c = 1'b1;
            else if (a_valid) gnt_a = 1'b1;
            else if (b_valid) gnt_b = 1'b1;
            else if (c_valid) gnt_c = 1'b1;
        end
    end

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;
    assign c_ready = gnt_c;

    always_comb begin
        opcode_d = opcode_q;
        data_d   = data_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        if (load) begin
            valid_d = gnt_a || gnt_b || gnt_c;
            tag_d   = (gnt_a || gnt_b || gnt_c) ? tag_q + 3'd1 : tag_q;
            if (gnt_a) begin
                opcode_d = {1'b1, tag_q};
                data_d   = a_data;
            end else if (gnt_b) begin
                opcode_d = {2'b01, tag_q[1:0]};
                data_d   = b_data;
            end else if (gnt_c) begin
                opcode_d = {3'b001, tag_q[0]};
                data_d   = c_data;
            end else begin
                opcode_d = 4'b0000;
            end
        end
    end

    // Waiting counts include stall cycles; grant or dropped valid clears.
    always_comb begin
        b_cnt_d = b_cnt_q;
        c_cnt_d = c_cnt_q;
        if (gnt_b || !b_valid)   b_cnt_d = '0;
        else if (b_cnt_q != LIMIT) b_cnt_d = b_cnt_q + CNT_W'(1);
        if (gnt_c || !c_valid)   c_cnt_d = '0;
        else if (c_cnt_q != LIMIT) c_cnt_d = c_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q <= 4'b0000;
            data_q   <= 2'b00;
            valid_q  <= 1'b0;
            tag_q    <= 3'b000;
            b_cnt_q  <= '0;
            c_cnt_q  <= '0;
        end else begin
            opcode_q <= opcode_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            b_cnt_q  <= b_cnt_d;
            c_cnt_q  <= c_cnt_d;
        end
    end

    assign opcode    = opcode_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_opcode_encoder.sv
// Bench for opcode_encoder: directed literal sequences plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_opcode_encoder;

    localparam int SL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
    logic [1:0] a_data = 2'b00, b_data = 2'b00, c_data = 2'b00;
    logic       a_ready, b_ready, c_ready;
    logic [3:0] opcode;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    opcode_encoder #(.STARVE_LIMIT(SL), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
        .opcode(opcode), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: waiting ages per source, rolling tag, output slot.
    bit m_ok = 0;
    int m_op, m_data, m_valid, m_tag, wb, wc;

    always @(negedge clk) begin
        int g;
        bit ld;
        g = 0;
        ld = (m_valid == 0) || out_ready;
        if (m_ok) begin
            chk("opcode", opcode, m_op[7:0]);
            chk("out_data", out_data, m_data[7:0]);
            chk("out_valid", out_valid, m_valid[7:0]);
        end
        if (!reset && m_ok && ld) begin
            if (b_valid && wb == SL)      g = 2;
            else if (c_valid && wc == SL) g = 3;
            else if (a_valid)             g = 1;
            else if (b_valid)             g = 2;
            else if (c_valid)             g = 3;
        end
        if (reset || m_ok) begin
            chk("a_ready", a_ready, (g == 1) ? 8'd1 : 8'd0);
            chk("b_ready", b_ready, (g == 2) ? 8'd1 : 8'd0);
            chk("c_ready", c_ready, (g == 3) ? 8'd1 : 8'd0);
        end
        if (reset) begin
            m_ok = 1;
            m_op = 0; m_data = 0; m_valid = 0; m_tag = 0; wb = 0; wc = 0;
        end else if (m_ok) begin
            wb = (g == 2 || !b_valid) ? 0 : ((wb + 1 > SL) ? SL : wb + 1);
            wc = (g == 3 || !c_valid) ? 0 : ((wc + 1 > SL) ? SL : wc + 1);
            if (ld) begin
                case (g)
                    1: begin m_op = 8 + m_tag;       m_data = int'(a_data); end
                    2: begin m_op = 4 + (m_tag % 4); m_data = int'(b_data); end
                    3: begin m_op = 2 + (m_tag % 2); m_data = int'(c_data); end
                    default: m_op = 0;
                endcase
                m_valid = (g != 0) ? 1 : 0;
                if (g != 0) m_tag = (m_tag + 1) % 8;
            end
        end
    end

    int exp_op[7] = '{8, 9, 10, 11, 4, 3, 14};

    initial begin
        // Reset with a source already valid: no ready may leak out
        a_valid = 1'b1; out_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_opcode", opcode, 8'h0);
        chk("rst_valid", out_valid, 8'h0);
        chk("rst_a_ready", a_ready, 8'h0);
        reset = 1'b0; a_data = 2'b00;
        #1 chk("first_a_ready", a_ready, 8'h1);
        cyc();
        chk("first_opcode", opcode, 8'h8);
        chk("first_valid", out_valid, 8'h1);
        a_data = 2'b11;
        cyc();
        chk("second_opcode", opcode, 8'h9);
        chk("second_data", out_data, 8'h3);

        // Starvation order: a x4, starved b, starved c, then a again
        reset = 1'b1; a_valid = 1'b0;
        cyc();
        reset = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
        a_data = 2'd1; b_data = 2'd2; c_data = 2'd3;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk($sformatf("starve_op%0d", i), opcode, exp_op[i][7:0]);
        end

        // Reset while holding a valid output
        out_ready = 1'b0; b_valid = 1'b0; c_valid = 1'b0; reset = 1'b1;
        cyc();
        chk("midrst_valid", out_valid, 8'h0);
        chk("midrst_opcode", opcode, 8'h0);
        reset = 1'b0; out_ready = 1'b1; a_data = 2'd2;
        cyc();
        chk("post_rst_op", opcode, 8'h8);
        chk("post_rst_data", out_data, 8'h2);

        // Backpressure with c waiting
        a_valid = 1'b0; out_ready = 1'b0; c_valid = 1'b1; c_data = 2'd1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_c_ready", c_ready, 8'h0);
            cyc();
            chk("stall_opcode", opcode, 8'h8);
            chk("stall_data", out_data, 8'h2);
        end
        out_ready = 1'b1;
        #1 chk("unstall_c_ready", c_ready, 8'h1);
        cyc();
        chk("unstall_opcode", opcode, 8'h3);

        // c alone: low tag bit toggles, tag wraps through 7
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("c_only_op", opcode, 8'(2 + ((2 + i) % 2)));
        end

        // Random traffic, occasional reset, mostly-ready downstream
        for (int i = 0; i < 3000; i++) begin
            cyc();
            reset     = ($urandom_range(0, 149) == 0);
            a_valid   = ($urandom_range(0, 2) == 0);
            b_valid   = ($urandom_range(0, 1) == 0);
            c_valid   = ($urandom_range(0, 1) == 0);
            a_data    = 2'($urandom);
            b_data    = 2'($urandom);
            c_data    = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        reset = 1'b0;
        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
